// File: rtl/pio_input_debouncer_if.sv
// pio_input_debouncer_if: switch/key inputs and debounced results of the PIO debouncer
// Signals: raw_in (asynchronous board inputs), debounced_out (conditioned levels),
//          rise_pulse / fall_pulse (per-bit one-cycle edge pulses), any_change (OR of all pulses).
// Modports: master drives raw_in and observes the results; slave is the debouncer side.
interface pio_input_debouncer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] debounced_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             any_change;
    modport master (output raw_in, input debounced_out, rise_pulse, fall_pulse, any_change);
    modport slave  (input raw_in, output debounced_out, rise_pulse, fall_pulse, any_change);
endinterface

// File: rtl/pio_input_debouncer.sv
// pio_input_debouncer: per-bit synchronizer and stability-counter debouncer for PIO switch inputs
// Ports: clk (rising-edge clock), reset (synchronous, active-high),
//        bus (pio_input_debouncer_if.slave: raw_in in; debounced_out, rise_pulse, fall_pulse, any_change out).
// Macro PIO_DEBOUNCE_EDGE_EN: when defined, builds the registered edge pulses; otherwise they are tied to 0.
module pio_input_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input logic                  clk,
    input logic                  reset,
    pio_input_debouncer_if.slave bus
);
    typedef enum logic {STABLE, COUNTING} state_t;
    localparam logic [15:0] LIMIT = 16'(DEBOUNCE_CYCLES);
    logic [WIDTH-1:0] sync1, sync2, level;
`ifdef PIO_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] toggle, rise, fall;
    logic             any;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.raw_in;
            sync2 <= sync1;
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        state_t      state, state_nxt;
        logic [15:0] cnt, cnt_nxt, cnt_inc;
        logic        lvl, differ, tog;
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= STABLE;
                cnt   <= '0;
                lvl   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                lvl   <= lvl ^ tog;
            end
        end
        // The level is accepted on the cycle the count would reach the limit, so the
        // counter never holds a value above DEBOUNCE_CYCLES - 1 and latency is DEBOUNCE_CYCLES + 2.
        always_comb begin
            cnt_inc   = (state == STABLE) ? 16'd1 : cnt + 16'd1;
            differ    = sync2[i] != lvl;
            tog       = differ && (cnt_inc == LIMIT);
            state_nxt = (differ && !tog) ? COUNTING : STABLE;
            cnt_nxt   = (differ && !tog) ? cnt_inc : 16'd0;
        end
        assign level[i] = lvl;
`ifdef PIO_DEBOUNCE_EDGE_EN
        assign toggle[i] = tog;
`endif
    end
    assign bus.debounced_out = level;
`ifdef PIO_DEBOUNCE_EDGE_EN
    // Pulses register alongside the level so they line up with the debounced_out change.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= '0;
            fall <= '0;
            any  <= 1'b0;
        end else begin
            rise <= toggle & ~level;
            fall <= toggle & level;
            any  <= |toggle;
        end
    end
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;
    assign bus.any_change = any;
`else
    assign bus.rise_pulse = '0;
    assign bus.fall_pulse = '0;
    assign bus.any_change = 1'b0;
`endif
endmodule

// File: tb/tb_pio_input_debouncer.sv
// tb_pio_input_debouncer: directed self-checking bench for pio_input_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4)
module tb_pio_input_debouncer;
`ifdef PIO_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    pio_input_debouncer_if #(.WIDTH(8)) bus ();
    pio_input_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.raw_in = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            checks++;
            if (bus.debounced_out !== 8'h00 || bus.rise_pulse !== 8'h00 || bus.fall_pulse !== 8'h00 || bus.any_change !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: dout=%h rise=%h fall=%h any=%b required all 0", bus.debounced_out, bus.rise_pulse, bus.fall_pulse, bus.any_change);
            end
        end
        bus.raw_in = 8'h00;
        tick(1);
        reset = 1'b0;
        tick(3);
        checks++;
        if (bus.debounced_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: dout=%h required 00", bus.debounced_out);
        end
    endtask

    task automatic test_rise();
        bus.raw_in = 8'h01;
        tick(5);
        checks++;
        if (bus.debounced_out !== 8'h00 || bus.rise_pulse !== 8'h00) begin
            errors++;
            $display("FAIL rise_early: dout=%h rise=%h required 00 00", bus.debounced_out, bus.rise_pulse);
        end
        tick(1);
        checks++;
        if (bus.debounced_out !== 8'h01 || bus.rise_pulse !== (EDGE_EN ? 8'h01 : 8'h00) || bus.any_change !== EDGE_EN || bus.fall_pulse !== 8'h00) begin
            errors++;
            $display("FAIL rise_accept: dout=%h rise=%h fall=%h any=%b required 01 %h 00 %b", bus.debounced_out, bus.rise_pulse, bus.fall_pulse, bus.any_change, EDGE_EN ? 8'h01 : 8'h00, EDGE_EN);
        end
        tick(1);
        checks++;
        if (bus.debounced_out !== 8'h01 || bus.rise_pulse !== 8'h00 || bus.any_change !== 1'b0) begin
            errors++;
            $display("FAIL rise_one_cycle: dout=%h rise=%h any=%b required 01 00 0", bus.debounced_out, bus.rise_pulse, bus.any_change);
        end
        bus.raw_in = 8'h00;
        tick(8);
        checks++;
        if (bus.debounced_out !== 8'h00) begin
            errors++;
            $display("FAIL rise_restore: dout=%h required 00", bus.debounced_out);
        end
    endtask

    task automatic test_glitch();
        bus.raw_in = 8'h04;
        tick(3);
        bus.raw_in = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            checks++;
            if (bus.debounced_out !== 8'h00 || bus.rise_pulse !== 8'h00 || bus.fall_pulse !== 8'h00 || bus.any_change !== 1'b0) begin
                errors++;
                $display("FAIL glitch cycle %0d: dout=%h rise=%h fall=%h any=%b required all 0", c, bus.debounced_out, bus.rise_pulse, bus.fall_pulse, bus.any_change);
            end
        end
    endtask

    task automatic test_fall();
        bus.raw_in = 8'hFF;
        tick(6);
        checks++;
        if (bus.debounced_out !== 8'hFF || bus.rise_pulse !== (EDGE_EN ? 8'hFF : 8'h00)) begin
            errors++;
            $display("FAIL fall_settle: dout=%h rise=%h required FF %h", bus.debounced_out, bus.rise_pulse, EDGE_EN ? 8'hFF : 8'h00);
        end
        tick(3);
        bus.raw_in = 8'h00;
        tick(5);
        checks++;
        if (bus.debounced_out !== 8'hFF || bus.fall_pulse !== 8'h00) begin
            errors++;
            $display("FAIL fall_early: dout=%h fall=%h required FF 00", bus.debounced_out, bus.fall_pulse);
        end
        tick(1);
        checks++;
        if (bus.debounced_out !== 8'h00 || bus.fall_pulse !== (EDGE_EN ? 8'hFF : 8'h00) || bus.rise_pulse !== 8'h00 || bus.any_change !== EDGE_EN) begin
            errors++;
            $display("FAIL fall_accept: dout=%h fall=%h rise=%h any=%b required 00 %h 00 %b", bus.debounced_out, bus.fall_pulse, bus.rise_pulse, bus.any_change, EDGE_EN ? 8'hFF : 8'h00, EDGE_EN);
        end
        tick(1);
        checks++;
        if (bus.fall_pulse !== 8'h00 || bus.any_change !== 1'b0) begin
            errors++;
            $display("FAIL fall_one_cycle: fall=%h any=%b required 00 0", bus.fall_pulse, bus.any_change);
        end
    endtask

    task automatic test_reset_mid_count();
        bus.raw_in = 8'h80;
        tick(3);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            checks++;
            if (bus.debounced_out !== 8'h00 || bus.rise_pulse !== 8'h00 || bus.fall_pulse !== 8'h00 || bus.any_change !== 1'b0) begin
                errors++;
                $display("FAIL midreset_hold %0d: dout=%h rise=%h fall=%h any=%b required all 0", c, bus.debounced_out, bus.rise_pulse, bus.fall_pulse, bus.any_change);
            end
        end
        reset = 1'b0;
        tick(5);
        checks++;
        if (bus.debounced_out !== 8'h00) begin
            errors++;
            $display("FAIL midreset_early: dout=%h required 00", bus.debounced_out);
        end
        tick(1);
        checks++;
        if (bus.debounced_out !== 8'h80 || bus.rise_pulse !== (EDGE_EN ? 8'h80 : 8'h00) || bus.any_change !== EDGE_EN) begin
            errors++;
            $display("FAIL midreset_accept: dout=%h rise=%h any=%b required 80 %h %b", bus.debounced_out, bus.rise_pulse, bus.any_change, EDGE_EN ? 8'h80 : 8'h00, EDGE_EN);
        end
    endtask

    task automatic test_toggle();
        for (int c = 0; c < 24; c++) begin
            bus.raw_in = {1'b1, 6'b0, c[1]};
            tick(1);
            checks++;
            if (bus.debounced_out !== 8'h80 || bus.any_change !== 1'b0) begin
                errors++;
                $display("FAIL toggle cycle %0d: dout=%h any=%b required 80 0", c, bus.debounced_out, bus.any_change);
            end
        end
        bus.raw_in = 8'h80;
        tick(8);
    endtask

    task automatic test_multi();
        reset = 1'b1;
        bus.raw_in = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(2);
        bus.raw_in = 8'h0F;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            checks++;
            if (bus.debounced_out !== (c >= 6 ? 8'h0F : 8'h00) || bus.rise_pulse !== ((c == 6 && EDGE_EN) ? 8'h0F : 8'h00) || bus.fall_pulse !== 8'h00 || bus.any_change !== (c == 6 && EDGE_EN)) begin
                errors++;
                $display("FAIL multi edge %0d: dout=%h rise=%h fall=%h any=%b", c, bus.debounced_out, bus.rise_pulse, bus.fall_pulse, bus.any_change);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.raw_in = 8'h00;
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_reset_mid_count();
        test_toggle();
        test_multi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_input_debouncer.md
PIO_INPUT_DEBOUNCER -- requirements
Module: pio_input_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent input bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable cycles required before accepting a new level (legal range 1..65535).
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port raw_in  input  WIDTH: asynchronous switch/key inputs from the board.
REQ-006 SHALL have port debounced_out  output  WIDTH: conditioned levels, drives the PIO input port directly.
REQ-007 SHALL have port rise_pulse  output  WIDTH: one-cycle pulse per bit on an accepted 0->1 change.
REQ-008 SHALL have port fall_pulse  output  WIDTH: one-cycle pulse per bit on an accepted 1->0 change.
REQ-009 SHALL have port any_change  output  1: OR of all rise_pulse and fall_pulse bits, same cycle.

Function
REQ-010 SHALL pass each raw_in bit through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL keep one 16-bit counter and one accepted-level register per bit.
REQ-012 SHALL operate each bit as a 2-state machine: STABLE (sync2 == accepted level, counter 0) and COUNTING (sync2 != accepted level).
REQ-013 SHALL in STABLE, on sync2 != accepted level, enter COUNTING with counter loaded to 1.
REQ-014 SHALL in COUNTING, on sync2 == accepted level (glitch), return to STABLE and clear counter; no output change, no pulse.
REQ-015 SHALL in COUNTING, on sync2 != accepted level and counter == DEBOUNCE_CYCLES, toggle accepted level, clear counter, return to STABLE; otherwise increment counter.
REQ-016 SHALL never let the counter exceed DEBOUNCE_CYCLES (no wrap-around).
REQ-017 SHALL give latency from a clean raw_in edge to debounced_out change of exactly DEBOUNCE_CYCLES+2 clock edges.
REQ-018 SHALL with DEBOUNCE_CYCLES = 1 accept any sync2 level that differs for one cycle (latency 3 edges).
REQ-019 SHALL register rise_pulse/fall_pulse so they assert in the same cycle debounced_out changes, for exactly one cycle.
REQ-020 SHALL process all bits independently; simultaneous changes on several bits give simultaneous pulses.
REQ-021 SHALL drive debounced_out from the accepted-level registers with no combinational path from raw_in.

Reset
REQ-022 SHALL on reset clear sync1, sync2, all counters, debounced_out, rise_pulse, fall_pulse and any_change to 0.
REQ-023 SHALL when reset asserts mid-count discard the count; a raw_in held at 1 through reset produces a rise_pulse DEBOUNCE_CYCLES+2 edges after reset deasserts.
REQ-024 SHALL hold all outputs at 0 for every cycle reset is high, regardless of raw_in.

Configuration
REQ-025 SHALL implement macro PIO_DEBOUNCE_EDGE_EN: when defined, rise_pulse, fall_pulse and any_change behave per REQ-019/REQ-020/REQ-009.
REQ-026 SHALL when PIO_DEBOUNCE_EDGE_EN is undefined keep all ports but tie rise_pulse, fall_pulse and any_change to constant 0 with no edge logic synthesized; debounced_out behaviour unchanged.

Verification (bench uses WIDTH=8, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-027 SHALL cover: raw_in 0x00->0x01 held -> debounced_out 0x01 exactly 6 edges later, rise_pulse 0x01 and any_change 1 for that single cycle.
REQ-028 SHALL cover: raw_in bit 2 high for 3 cycles then low -> debounced_out stays 0x00, no pulses.
REQ-029 SHALL cover: raw_in 0xFF->0x00 after settled 0xFF -> fall_pulse 0xFF for one cycle 6 edges later, debounced_out 0x00.
REQ-030 SHALL cover: raw_in 0x80 applied, reset pulsed high 2 cycles mid-count -> outputs 0 during reset, debounced_out 0x80 6 edges after reset release.
REQ-031 SHALL cover: raw_in bit 0 toggling every 2 cycles indefinitely -> debounced_out bit 0 never changes.
REQ-032 SHALL cover: macro undefined, raw_in 0x00->0x0F -> debounced_out 0x0F after 6 edges, rise_pulse/fall_pulse/any_change constantly 0.
